// File: rtl/store_buffer_unit_pkg.sv
// Shared types for the store buffer: store opcodes and the queued entry.
// XLEN is taken from the SB_XLEN macro (default 32).
`ifndef SB_XLEN
`define SB_XLEN 32
`endif
package store_buffer_unit_pkg;
  localparam int XLEN_P  = `SB_XLEN;
  localparam int NBYTE_P = XLEN_P / 8;

  typedef enum logic [2:0] {
    STR_NOP = 3'd0,
    STR_SB  = 3'd1,
    STR_SH  = 3'd2,
    STR_SW  = 3'd3,
    STR_SD  = 3'd4
  } str_op_e;

  typedef struct packed {
    logic [XLEN_P-1:0]  addr;
    logic [XLEN_P-1:0]  data;
    logic [NBYTE_P-1:0] be;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_unit_if.sv
// Memory write port of the store buffer: req/gnt handshake plus head entry.
// master = store buffer (drives req/addr/data/be), slave = memory (drives gnt).
interface store_buffer_unit_if #(
  parameter int XLEN = 32
) ();
  localparam int NBYTE = XLEN / 8;

  logic             mem_req;
  logic             mem_gnt;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_write_data;
  logic [NBYTE-1:0] mem_byte_en;

  modport master (
    output mem_req, mem_addr,
    output mem_write_data, mem_byte_en,
    input  mem_gnt
  );

  modport slave (
    input  mem_req, mem_addr,
    input  mem_write_data, mem_byte_en,
    output mem_gnt
  );
endinterface

// File: rtl/store_buffer_unit_align.sv
// store_lane_align: byte-lane placement and alignment check for one store.
// Ports: off/op/rs2 in; be, data, misaligned, legal (known store code) out.
module store_lane_align
  import store_buffer_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NBYTE = XLEN / 8,
  localparam int OFFW = $clog2(NBYTE)
) (
  input  logic [OFFW-1:0]  off,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs2,
  output logic [NBYTE-1:0] be,
  output logic [XLEN-1:0]  data,
  output logic             misaligned,
  output logic             legal
);
  logic is_sb, is_sh, is_sw, is_sd;
  logic [NBYTE-1:0] be_base;
  logic [XLEN-1:0]  shifted;

  assign is_sb = (op == STR_SB);
  assign is_sh = (op == STR_SH);
  assign is_sw = (op == STR_SW);
  // SD only exists on a 64-bit datapath
  assign is_sd = (op == STR_SD) && (XLEN == 64);

  assign legal = is_sb | is_sh | is_sw | is_sd;

  assign misaligned = (is_sh & off[0])
                    | (is_sw & (|off[1:0]))
                    | (is_sd & (|off));

  always_comb begin
    be_base = '0;
    unique case (1'b1)
      is_sb:   be_base = NBYTE'(1);
      is_sh:   be_base = NBYTE'(3);
      is_sw:   be_base = NBYTE'(15);
      is_sd:   be_base = '1;
      default: be_base = '0;
    endcase
  end

  assign be      = be_base << off;
  assign shifted = rs2 << {off, 3'b000};

  // lanes outside the enable mask are forced to zero
  always_comb begin
    data = '0;
    for (int i = 0; i < NBYTE; i++) begin
      data[8*i +: 8] = be[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end
endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: address gen, lane align, DEPTH-entry FIFO drained over mem if.
// Ports: clk/rst, execute store inputs, stall/misaligned, load hazard, mem port.
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_P,
  parameter int DEPTH = 4,
  localparam int NBYTE = XLEN / 8,
  localparam int OFFW = $clog2(NBYTE),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      store_control,
  output logic            stall_pc,
  output logic            misaligned,
  input  logic [XLEN-1:0] ld_check_addr,
  output logic            ld_hazard,
  output logic [CW-1:0]   sb_count,
  output logic            sb_empty,
  store_buffer_unit_if.master mem
);
  logic [XLEN-1:0]  addr;
  logic [NBYTE-1:0] al_be;
  logic [XLEN-1:0]  al_data;
  logic             al_mis, al_legal;
  logic             store_ok, push, pop, full;
  sb_entry_t        ent, head;

  sb_entry_t        buf_q [DEPTH];
  sb_entry_t        buf_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  assign addr = rs1_val + imm;

  store_lane_align #(.XLEN(XLEN)) u_align (
    .off        (addr[OFFW-1:0]),
    .op         (store_control),
    .rs2        (rs2_val),
    .be         (al_be),
    .data       (al_data),
    .misaligned (al_mis),
    .legal      (al_legal)
  );

  assign ent = '{addr: addr, data: al_data, be: al_be};

  assign store_ok   = al_legal & ~al_mis & ~i_rst;
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = mem.mem_req & mem.mem_gnt;
  // a full buffer still accepts when the head leaves this cycle
  assign push       = store_ok & (~full | pop);
  assign stall_pc   = store_ok & ~push;
  assign misaligned = al_legal & al_mis & ~i_rst;

  assign sb_count = i_rst ? '0 : count_q;
  assign sb_empty = i_rst | (count_q == '0);

  assign head = sb_empty ? '0 : buf_q[head_q];

  assign mem.mem_req        = ~sb_empty;
  assign mem.mem_addr       = head.addr;
  assign mem.mem_write_data = head.data;
  assign mem.mem_byte_en    = head.be;

  // word-granular match; the entry leaving this cycle is still valid here
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] &&
          (((buf_q[i].addr ^ ld_check_addr) >> OFFW) == '0))
        ld_hazard = 1'b1;
    end
    ld_hazard = ld_hazard & ~i_rst;
  end

  always_comb begin
    buf_d   = buf_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      buf_d[tail_q] = ent;
      tail_d        = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end
endmodule

// File: tb/tb_store_buffer_unit.sv
// Testbench for store_buffer_unit: vector table plus multi-cycle sequences.
// Drained entries are checked against a queue of expected stores.
module tb_store_buffer_unit;
  import store_buffer_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1, rs2, imm, ldc;
  logic [2:0]  op;
  logic        stall, mis, haz, empty;
  logic [2:0]  cnt;

  int errs   = 0;
  int checks = 0;

  store_buffer_unit_if #(.XLEN(32)) mif ();

  store_buffer_unit #(.XLEN(32), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .rs1_val       (rs1),
    .rs2_val       (rs2),
    .imm           (imm),
    .store_control (op),
    .stall_pc      (stall),
    .misaligned    (mis),
    .ld_check_addr (ldc),
    .ld_hazard     (haz),
    .sb_count      (cnt),
    .sb_empty      (empty),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1, imm, rs2;
    logic        mis, push;
    logic [31:0] addr, data;
    logic [3:0]  be;
  } vec_t;

  vec_t      v [12];
  sb_entry_t q [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(logic [2:0] o, logic [31:0] a,
                     logic [31:0] i, logic [31:0] d);
    op = o; rs1 = a; imm = i; rs2 = d;
  endtask

  function automatic sb_entry_t mk(logic [31:0] a, logic [31:0] d,
                                   logic [3:0] b);
    sb_entry_t e;
    e.addr = a; e.data = d; e.be = b;
    return e;
  endfunction

  // scoreboard: every granted head must match the oldest expected store
  always @(negedge clk) begin
    sb_entry_t e;
    #2;
    if (rst === 1'b0 && mif.mem_req === 1'b1 && mif.mem_gnt === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", 64'(mif.mem_addr), 64'hFFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("pop_addr", 64'(mif.mem_addr), 64'(e.addr));
        chk("pop_data", 64'(mif.mem_write_data), 64'(e.data));
        chk("pop_be", 64'(mif.mem_byte_en), 64'(e.be));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{STR_SW, 32'h1000, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1,
              32'h1004, 32'hDEADBEEF, 4'hF};
    v[1]  = '{STR_SB, 32'h1000, 32'h3, 32'h000000AB, 1'b0, 1'b1,
              32'h1003, 32'hAB000000, 4'h8};
    v[2]  = '{STR_SH, 32'h1000, 32'h2, 32'h00001234, 1'b0, 1'b1,
              32'h1002, 32'h12340000, 4'hC};
    v[3]  = '{STR_SH, 32'h1000, 32'h1, 32'h00001234, 1'b1, 1'b0,
              32'h0, 32'h0, 4'h0};
    v[4]  = '{STR_SB, 32'h1000, 32'h1, 32'h11223344, 1'b0, 1'b1,
              32'h1001, 32'h00004400, 4'h2};
    v[5]  = '{STR_SW, 32'h1000, 32'h2, 32'h55667788, 1'b1, 1'b0,
              32'h0, 32'h0, 4'h0};
    v[6]  = '{STR_SH, 32'h1000, 32'h0, 32'hAAAA5555, 1'b0, 1'b1,
              32'h1000, 32'h00005555, 4'h3};
    v[7]  = '{3'd4, 32'h1000, 32'h0, 32'h12345678, 1'b0, 1'b0,
              32'h0, 32'h0, 4'h0};
    v[8]  = '{3'd7, 32'h1001, 32'h0, 32'h12345678, 1'b0, 1'b0,
              32'h0, 32'h0, 4'h0};
    v[9]  = '{STR_SW, 32'h2000, 32'hFFFFFFFC, 32'h01020304, 1'b0, 1'b1,
              32'h1FFC, 32'h01020304, 4'hF};
    v[10] = '{STR_SB, 32'hFFFFFFFF, 32'h1, 32'h0000005A, 1'b0, 1'b1,
              32'h0, 32'h0000005A, 4'h1};
    v[11] = '{STR_SW, 32'h1000, 32'h3, 32'hCAFEF00D, 1'b1, 1'b0,
              32'h0, 32'h0, 4'h0};

    rst = 1'b1; ldc = '0; mif.mem_gnt = 1'b0;
    drv(STR_NOP, '0, '0, '0);

    // reset state, including a misaligned store presented during reset
    repeat (2) @(negedge clk);
    drv(STR_SH, 32'h1000, 32'h1, 32'h0);
    #2;
    chk("rst_req", 64'(mif.mem_req), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_mis", 64'(mis), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_addr", 64'(mif.mem_addr), 64'(0));
    chk("rst_data", 64'(mif.mem_write_data), 64'(0));
    chk("rst_be", 64'(mif.mem_byte_en), 64'(0));
    chk("rst_haz", 64'(haz), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    drv(STR_NOP, '0, '0, '0);

    // table vectors, memory always granting
    mif.mem_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drv(v[i].op, v[i].rs1, v[i].imm, v[i].rs2);
      #2;
      chk($sformatf("v%0d_mis", i), 64'(mis), 64'(v[i].mis));
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(0));
      chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(0));
      if (v[i].push) q.push_back(mk(v[i].addr, v[i].data, v[i].be));
      @(negedge clk);
      drv(STR_NOP, '0, '0, '0);
      #2;
      chk($sformatf("v%0d_req", i), 64'(mif.mem_req), 64'(v[i].push));
      @(negedge clk);
      #2;
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(1));
    end

    // fill to DEPTH with no grant, then push+pop while full
    mif.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(STR_SW, 32'h3000, 32'(4 * i), 32'hA0 + 32'(i));
      #2;
      chk($sformatf("fill%0d_stall", i), 64'(stall), 64'(0));
      q.push_back(mk(32'h3000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF));
    end
    @(negedge clk);
    drv(STR_SW, 32'h3000, 32'h10, 32'hA4);
    #2;
    chk("full_cnt", 64'(cnt), 64'(4));
    chk("full_stall", 64'(stall), 64'(1));
    chk("full_head", 64'(mif.mem_addr), 64'(32'h3000));
    @(negedge clk);
    #2;
    chk("hold_stall", 64'(stall), 64'(1));
    chk("hold_addr", 64'(mif.mem_addr), 64'(32'h3000));
    chk("hold_data", 64'(mif.mem_write_data), 64'(32'hA0));
    @(negedge clk);
    mif.mem_gnt = 1'b1;
    #2;
    chk("pp_stall", 64'(stall), 64'(0));
    q.push_back(mk(32'h3010, 32'hA4, 4'hF));
    @(negedge clk);
    drv(STR_NOP, '0, '0, '0);
    #2;
    chk("pp_cnt", 64'(cnt), 64'(4));
    repeat (4) @(negedge clk);
    #2;
    chk("drain_empty", 64'(empty), 64'(1));

    // load hazard against a buffered store
    mif.mem_gnt = 1'b0;
    @(negedge clk);
    drv(STR_SW, 32'h2008, 32'h0, 32'h77);
    ldc = 32'h2008;
    #2;
    chk("haz_push_ignored", 64'(haz), 64'(0));
    q.push_back(mk(32'h2008, 32'h77, 4'hF));
    @(negedge clk);
    drv(STR_NOP, '0, '0, '0);
    ldc = 32'h200A;
    #2;
    chk("haz_hit", 64'(haz), 64'(1));
    @(negedge clk);
    ldc = 32'h200C;
    #2;
    chk("haz_miss", 64'(haz), 64'(0));
    @(negedge clk);
    ldc = 32'h2008;
    mif.mem_gnt = 1'b1;
    #2;
    chk("haz_popping", 64'(haz), 64'(1));
    @(negedge clk);
    #2;
    chk("haz_gone", 64'(haz), 64'(0));
    chk("haz_empty", 64'(empty), 64'(1));

    // reset while three entries are pending
    mif.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(STR_SW, 32'h4000, 32'(4 * i), 32'hB0 + 32'(i));
    end
    @(negedge clk);
    drv(STR_NOP, '0, '0, '0);
    #2;
    chk("pre_rst_cnt", 64'(cnt), 64'(3));
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("mid_rst_req", 64'(mif.mem_req), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_cnt", 64'(cnt), 64'(0));
    chk("post_rst_empty", 64'(empty), 64'(1));
    chk("post_rst_req", 64'(mif.mem_req), 64'(0));

    // buffer usable again after reset
    mif.mem_gnt = 1'b1;
    @(negedge clk);
    drv(STR_SW, 32'h5000, 32'h0, 32'h600DF00D);
    q.push_back(mk(32'h5000, 32'h600DF00D, 4'hF));
    @(negedge clk);
    drv(STR_NOP, '0, '0, '0);
    repeat (2) @(negedge clk);
    #3;
    chk("sb_drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
